// File: rtl/tboom_rmt_checkpoint_ctrl_if.sv
// ---------------------------------------------------------------------------
// tboom_rmt_checkpoint_ctrl_if
// Bundle between decode/branch-unit and the RMT checkpoint slot manager.
//   master : the decode/branch-unit side (drives requests, resolves, mispredicts)
//   slave  : the checkpoint controller (drives grants, RMT strobes, status)
// Signals:
//   alloc_req/alloc_gnt/alloc_tag/alloc_ready : checkpoint allocation handshake
//   resolve_valid/resolve_tag                 : correct branch resolution
//   mispredict_valid/mispredict_tag           : branch mispredict
//   rmt_checkpoint/rmt_restore/rmt_pos        : RMT snapshot/restore controls
//   rename_stall, full, empty, count          : status
//   err_sticky                                : only with TBOOM_CKPT_ERR_EN
// ---------------------------------------------------------------------------
interface tboom_rmt_checkpoint_ctrl_if #(
  parameter int CHECKPOINT_DEPTH = 8
);
  localparam int TAG_W = $clog2(CHECKPOINT_DEPTH);

  logic             alloc_req;
  logic             alloc_gnt;
  logic [TAG_W-1:0] alloc_tag;
  logic             alloc_ready;
  logic             resolve_valid;
  logic [TAG_W-1:0] resolve_tag;
  logic             mispredict_valid;
  logic [TAG_W-1:0] mispredict_tag;
  logic             rmt_checkpoint;
  logic             rmt_restore;
  logic [TAG_W-1:0] rmt_pos;
  logic             rename_stall;
  logic             full;
  logic             empty;
  logic [TAG_W:0]   count;
`ifdef TBOOM_CKPT_ERR_EN
  logic             err_sticky;
`endif

  modport master (
    output alloc_req, resolve_valid, resolve_tag, mispredict_valid, mispredict_tag,
    input  alloc_gnt, alloc_tag, alloc_ready, rmt_checkpoint, rmt_restore, rmt_pos,
           rename_stall, full, empty, count
`ifdef TBOOM_CKPT_ERR_EN
    , input err_sticky
`endif
  );

  modport slave (
    input  alloc_req, resolve_valid, resolve_tag, mispredict_valid, mispredict_tag,
    output alloc_gnt, alloc_tag, alloc_ready, rmt_checkpoint, rmt_restore, rmt_pos,
           rename_stall, full, empty, count
`ifdef TBOOM_CKPT_ERR_EN
    , output err_sticky
`endif
  );
endinterface

// File: rtl/tboom_rmt_checkpoint_ctrl.sv
// ---------------------------------------------------------------------------
// tboom_rmt_checkpoint_ctrl
// Checkpoint-slot manager and mispredict recovery sequencer for the rename map
// table checkpoint buffer. Slots are handed to branches in program order as a
// circular queue (head = oldest live slot, tail = next slot to allocate).
// Correctly resolved slots retire in order from head; a mispredict discards the
// mispredicted slot and everything younger, pulses the RMT restore and stalls
// rename for two cycles (RESTORE, SETTLE).
// Ports:
//   clk   : clock, all state updates on posedge
//   rst_n : synchronous active-low reset
//   bus   : tboom_rmt_checkpoint_ctrl_if.slave (alloc/resolve/mispredict in,
//           grant, RMT checkpoint/restore controls and status out)
// Optional: define TBOOM_CKPT_ERR_EN to add bus.err_sticky, a sticky flag for
// protocol violations (non-live resolve/mispredict, mispredict outside IDLE,
// alloc_req while full).
// ---------------------------------------------------------------------------
module tboom_rmt_checkpoint_ctrl #(
  parameter int CHECKPOINT_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  tboom_rmt_checkpoint_ctrl_if.slave  bus
);
  localparam int TAG_W = $clog2(CHECKPOINT_DEPTH);

  typedef enum logic [1:0] {IDLE, RESTORE, SETTLE} state_t;

  state_t                      state_q, state_next;
  logic [TAG_W-1:0]            head_q, tail_q, restore_tag_q;
  logic [TAG_W:0]              count_q, count_next;
  logic [CHECKPOINT_DEPTH-1:0] live_q, done_q, live_next, done_next, flush_mask;

  logic             full, empty, alloc_ready, alloc_gnt;
  logic             retire, mp_acc, res_apply;
  logic             rmt_restore, rename_stall;
  logic [TAG_W-1:0] mp_off, res_off;

  // Age of a tag is its distance from head; smaller offset means older.
  assign mp_off  = bus.mispredict_tag - head_q;
  assign res_off = bus.resolve_tag - head_q;

  assign full  = (count_q == (TAG_W+1)'(CHECKPOINT_DEPTH));
  assign empty = (count_q == '0);

  assign mp_acc = bus.mispredict_valid && (state_q == IDLE) && live_q[bus.mispredict_tag];

  // Any mispredict request blocks the grant, so a mispredict always wins
  // over a same-cycle allocation.
  assign alloc_ready = (state_q == IDLE) && !full && !bus.mispredict_valid;
  assign alloc_gnt   = bus.alloc_req && alloc_ready;

  // A mispredict on head flushes head itself, so it cannot retire as well.
  assign retire = live_q[head_q] && done_q[head_q] && !(mp_acc && (mp_off == '0));

  // A resolve racing an accepted mispredict survives only for older slots.
  assign res_apply = bus.resolve_valid && live_q[bus.resolve_tag] &&
                     (!mp_acc || (res_off < mp_off));

  // NOTE: every signal written here gets a default first, so partial
  // assignment under the if-chain cannot infer a latch.
  always_comb begin
    flush_mask = '0;
    live_next  = live_q;
    done_next  = done_q;
    for (int i = 0; i < CHECKPOINT_DEPTH; i++) begin
      flush_mask[i] = ((TAG_W'(i) - head_q) >= mp_off);
    end
    if (res_apply) done_next[bus.resolve_tag] = 1'b1;
    if (retire)    live_next[head_q] = 1'b0;
    if (alloc_gnt) begin
      live_next[tail_q] = 1'b1;
      done_next[tail_q] = 1'b0;
    end
    if (mp_acc)    live_next = live_next & ~flush_mask;
  end

  always_comb begin
    if (mp_acc) begin
      count_next = {1'b0, mp_off} - {{TAG_W{1'b0}}, retire};
    end else begin
      count_next = count_q + {{TAG_W{1'b0}}, alloc_gnt} - {{TAG_W{1'b0}}, retire};
    end
  end

  // NOTE: the live/done valid bits are reset along with the pointers; unlike a
  // data array they define which slots exist, so they must start cleared.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      live_q        <= '0;
      done_q        <= '0;
      restore_tag_q <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every update samples the
      // pre-edge state, independent of statement order.
      live_q  <= live_next;
      done_q  <= done_next;
      count_q <= count_next;
      if (retire)    head_q <= head_q + 1'b1;
      if (alloc_gnt) tail_q <= tail_q + 1'b1;
      if (mp_acc) begin
        tail_q        <= bus.mispredict_tag;
        restore_tag_q <= bus.mispredict_tag;
      end
    end
  end

  // Recovery FSM: state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_next;
  end

  // Recovery FSM: next state and outputs. SETTLE covers the RMT's registered
  // read latency before rename may resume.
  always_comb begin
    state_next   = state_q;
    rmt_restore  = 1'b0;
    rename_stall = 1'b0;
    unique case (state_q)
      IDLE:    if (mp_acc) state_next = RESTORE;
      RESTORE: begin
        rmt_restore  = 1'b1;
        rename_stall = 1'b1;
        state_next   = SETTLE;
      end
      SETTLE: begin
        rename_stall = 1'b1;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef TBOOM_CKPT_ERR_EN
  logic err_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if ((bus.resolve_valid && !live_q[bus.resolve_tag]) ||
                 (bus.mispredict_valid && ((state_q != IDLE) || !live_q[bus.mispredict_tag])) ||
                 (bus.alloc_req && full)) begin
      err_q <= 1'b1;
    end
  end
  assign bus.err_sticky = err_q;
`endif

  assign bus.alloc_gnt      = alloc_gnt;
  assign bus.alloc_tag      = tail_q;
  assign bus.alloc_ready    = alloc_ready;
  assign bus.rmt_checkpoint = alloc_gnt;
  assign bus.rmt_restore    = rmt_restore;
  assign bus.rmt_pos        = rmt_restore ? restore_tag_q : tail_q;
  assign bus.rename_stall   = rename_stall;
  assign bus.full           = full;
  assign bus.empty          = empty;
  assign bus.count          = count_q;

endmodule

// File: tb/tb_tboom_rmt_checkpoint_ctrl.sv
// ---------------------------------------------------------------------------
// tb_tboom_rmt_checkpoint_ctrl
// Directed bench for the RMT checkpoint controller (CHECKPOINT_DEPTH = 8).
// Inputs change 1 time unit after a rising edge; combinational outputs are
// checked 1 unit later, registered outputs 1 unit after the following edge.
// Define TBOOM_CKPT_ERR_EN to also exercise err_sticky.
// ---------------------------------------------------------------------------
module tb_tboom_rmt_checkpoint_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  tboom_rmt_checkpoint_ctrl_if #(.CHECKPOINT_DEPTH(8)) bus ();

  tboom_rmt_checkpoint_ctrl #(.CHECKPOINT_DEPTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clr();
    bus.alloc_req        = 1'b0;
    bus.resolve_valid    = 1'b0;
    bus.resolve_tag      = '0;
    bus.mispredict_valid = 1'b0;
    bus.mispredict_tag   = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clr();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Allocate n slots back to back, checking each granted tag.
  task automatic alloc_seq(input int n, input int first_tag);
    for (int i = 0; i < n; i++) begin
      bus.alloc_req = 1'b1;
      #1;
      check("alloc_gnt", bus.alloc_gnt, 1);
      check("alloc_tag", bus.alloc_tag, (first_tag + i) % 8);
      tick();
    end
    bus.alloc_req = 1'b0;
  endtask

  task automatic resolve(input int tag);
    bus.resolve_valid = 1'b1;
    bus.resolve_tag   = 3'(tag);
    tick();
    bus.resolve_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // ---- 1: reset state and fill ---------------------------------------
    do_reset();
    check("rst_empty", bus.empty, 1);
    check("rst_full", bus.full, 0);
    check("rst_count", bus.count, 0);
    check("rst_ready", bus.alloc_ready, 1);
    check("rst_stall", bus.rename_stall, 0);
    check("rst_restore", bus.rmt_restore, 0);
    for (int i = 0; i < 8; i++) begin
      bus.alloc_req = 1'b1;
      #1;
      check("fill_gnt", bus.alloc_gnt, 1);
      check("fill_ckpt", bus.rmt_checkpoint, 1);
      check("fill_tag", bus.alloc_tag, i);
      check("fill_pos", bus.rmt_pos, i);
      tick();
    end
    #1;
    check("fill_full", bus.full, 1);
    check("fill_count", bus.count, 8);
    check("ninth_gnt", bus.alloc_gnt, 0);
    check("ninth_ready", bus.alloc_ready, 0);
    check("ninth_ckpt", bus.rmt_checkpoint, 0);
    bus.alloc_req = 1'b0;

    // ---- 2: out-of-order resolve, in-order retire -----------------------
    do_reset();
    alloc_seq(4, 0);
    resolve(2);
    check("res2_count", bus.count, 4);
    resolve(0);
    check("res0_count", bus.count, 4);
    resolve(1);
    check("ret0_count", bus.count, 3);
    tick();
    check("ret1_count", bus.count, 2);
    tick();
    check("ret2_count", bus.count, 1);
    tick();
    check("hold3_count", bus.count, 1);
    alloc_seq(1, 4);

    // ---- 3: mispredict tag 2 with 0..5 live, racing an alloc -------------
    do_reset();
    alloc_seq(6, 0);
    bus.mispredict_valid = 1'b1;
    bus.mispredict_tag   = 3'd2;
    bus.alloc_req        = 1'b1;
    #1;
    check("mp_gnt", bus.alloc_gnt, 0);
    check("mp_ckpt", bus.rmt_checkpoint, 0);
    tick();
    clr();
    #1;
    check("restore_pulse", bus.rmt_restore, 1);
    check("restore_pos", bus.rmt_pos, 2);
    check("restore_stall", bus.rename_stall, 1);
    check("restore_ready", bus.alloc_ready, 0);
    check("restore_count", bus.count, 2);
    tick();
    check("settle_restore", bus.rmt_restore, 0);
    check("settle_stall", bus.rename_stall, 1);
    check("settle_ready", bus.alloc_ready, 0);
    tick();
    check("idle_stall", bus.rename_stall, 0);
    check("idle_ready", bus.alloc_ready, 1);
    alloc_seq(1, 2);
    check("post_mp_count", bus.count, 3);

    // ---- 4: wrap: head=6, tags 6,7,0,1 live, mispredict tag 7 ------------
    do_reset();
    alloc_seq(6, 0);
    for (int t = 0; t < 6; t++) resolve(t);
    tick();
    tick();
    check("drain_count", bus.count, 0);
    check("drain_empty", bus.empty, 1);
    alloc_seq(4, 6);
    check("wrap_count", bus.count, 4);
    bus.mispredict_valid = 1'b1;
    bus.mispredict_tag   = 3'd7;
    tick();
    clr();
    check("wrap_mp_count", bus.count, 1);
    check("wrap_pos", bus.rmt_pos, 7);
    tick();
    tick();
    alloc_seq(1, 7);
    check("wrap_after_count", bus.count, 2);

    // ---- 5a: mispredict 3 + resolve 1 (older: applied) -------------------
    do_reset();
    alloc_seq(6, 0);
    bus.mispredict_valid = 1'b1;
    bus.mispredict_tag   = 3'd3;
    bus.resolve_valid    = 1'b1;
    bus.resolve_tag      = 3'd1;
    bus.alloc_req        = 1'b1;
    #1;
    check("5a_gnt", bus.alloc_gnt, 0);
    tick();
    clr();
    check("5a_count", bus.count, 3);
    tick();
    tick();
    resolve(0);
    check("5a_res0", bus.count, 3);
    tick();
    check("5a_ret0", bus.count, 2);
    tick();
    check("5a_ret1", bus.count, 1);
    tick();
    check("5a_hold2", bus.count, 1);

    // ---- 5b: mispredict 3 + resolve 5 (younger: dropped) -----------------
    do_reset();
    alloc_seq(6, 0);
    bus.mispredict_valid = 1'b1;
    bus.mispredict_tag   = 3'd3;
    bus.resolve_valid    = 1'b1;
    bus.resolve_tag      = 3'd5;
    bus.alloc_req        = 1'b1;
    #1;
    check("5b_gnt", bus.alloc_gnt, 0);
    tick();
    clr();
    check("5b_count", bus.count, 3);
    tick();
    tick();
    for (int t = 0; t < 3; t++) resolve(t);
    tick();
    tick();
    check("5b_drain", bus.count, 0);
    alloc_seq(3, 3);
    tick();
    tick();
    check("5b_no_stale_done", bus.count, 3);

    // ---- 6: non-live mispredict ignored; reset during SETTLE -------------
    do_reset();
    alloc_seq(4, 0);
    bus.mispredict_valid = 1'b1;
    bus.mispredict_tag   = 3'd5;
    tick();
    clr();
    check("nonlive_mp_stall", bus.rename_stall, 0);
    check("nonlive_mp_count", bus.count, 4);
    bus.mispredict_valid = 1'b1;
    bus.mispredict_tag   = 3'd1;
    tick();
    clr();
    check("6_restore", bus.rmt_restore, 1);
    tick();
    check("6_settle_stall", bus.rename_stall, 1);
    rst_n = 1'b0;
    tick();
    check("6_rst_stall", bus.rename_stall, 0);
    check("6_rst_empty", bus.empty, 1);
    check("6_rst_count", bus.count, 0);
    check("6_rst_restore", bus.rmt_restore, 0);
    rst_n = 1'b1;
    tick();
    check("6_post_restore", bus.rmt_restore, 0);
    check("6_post_stall", bus.rename_stall, 0);
    alloc_seq(1, 0);

`ifdef TBOOM_CKPT_ERR_EN
    do_reset();
    check("err_rst", bus.err_sticky, 0);
    resolve(6);
    check("err_set", bus.err_sticky, 1);
    tick();
    check("err_hold", bus.err_sticky, 1);
    do_reset();
    check("err_clear", bus.err_sticky, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
